limbus_sys_perf_sampler: RTL and testbench
==========================================

LIMBUS_SYS_PERF_SAMPLER -- requirements
Module: limbus_sys_perf_sampler

Interface
REQ-001 SHALL have parameter NUM_SECTIONS, default 4, meaning the number of counter sections read per frame (1..4).
REQ-002 SHALL have parameter RD_LATENCY, default 1, meaning the cycles from read issue to valid avm_readdata (1..4).
REQ-003 SHALL have one clock and one reset; reset is synchronous and active-high.
REQ-004 SHALL have port clk, input, 1, the single clock.
REQ-005 SHALL have port reset, input, 1, synchronous active-high reset.
REQ-006 SHALL have port cfg_enable, input, 1, which enables periodic sampling.
REQ-007 SHALL have port cfg_period, input, 32, giving the sample period in clk cycles; 0 means no ticks.
REQ-008 SHALL have port cfg_clear, input, 1, requesting a counter global-reset write after each frame's reads.
REQ-009 SHALL have port avm_address, output, 4, the counter register address.
REQ-010 SHALL have ports avm_read, avm_write and avm_begintransfer, each output, 1, as single-cycle strobes.
REQ-011 SHALL have port avm_writedata, output, 32, the write data.
REQ-012 SHALL have port avm_readdata, input, 32, the counter read data.
REQ-013 SHALL have ports smp_data (output, 32), smp_valid (output, 1), smp_ready (input, 1), smp_sop (output, 1) and smp_eop (output, 1) forming the sample stream.
REQ-014 SHALL have ports busy (output, 1) and missed_cnt (output, 16), the saturating count of ticks dropped while busy.

Function
REQ-015 SHALL run a period counter while cfg_enable=1 and cfg_period!=0, producing a 1-cycle tick every cfg_period cycles; the counter reloads when cfg_enable rises or cfg_period changes.
REQ-016 SHALL start a frame on a tick in IDLE; a tick while not in IDLE SHALL increment missed_cnt, saturating at 0xFFFF.
REQ-017 SHALL follow the FSM IDLE -> HDR -> per section s: RD_HI0 -> RD_LO -> RD_HI1 -> RD_EV -> EMIT -> (next s | CLR | IDLE).
REQ-018 SHALL map section s to addresses time_lo=4s, time_hi=4s+1 and event=4s+2.
REQ-019 SHALL, in each RD_* state, assert avm_read for exactly 1 cycle, hold avm_address until capture, and capture avm_readdata exactly RD_LATENCY cycles after issue.
REQ-020 SHALL compare hi1 with hi0 and, if they differ, restart the section at RD_HI0; after 3 restarts it SHALL accept the hi1/lo pair and set the tear flag for the frame.
REQ-021 SHALL emit in HDR the word {tear_any[31], missed_cnt_sat8[30:23], 7'b0, seq[15:0]} with smp_sop=1; tear_any SHALL be updated into a trailing status instead (see REQ-022).
REQ-022 SHALL emit in EMIT, in order, time_lo, time_hi, event[31:0]; after the last section it SHALL emit a status word {tear_any, 31'b0} with smp_eop=1, giving a frame length of 2+3*NUM_SECTIONS words.
REQ-023 SHALL hold smp_data, smp_sop and smp_eop stable while smp_valid=1 and smp_ready=0, and complete a word only when smp_valid&smp_ready.
REQ-024 SHALL let the header word HDR carry the tear bit as 0; the authoritative tear indication SHALL be the status word.
REQ-025 SHALL, in CLR (entered only if cfg_clear=1), issue one cycle of avm_write=1, avm_begintransfer=1, avm_address=0 and avm_writedata=1, then go to IDLE.
REQ-026 SHALL increment seq (16-bit, wrapping 0xFFFF->0) on each completed frame.
REQ-027 SHALL hold busy=1 in every state except IDLE.
REQ-028 SHALL let a frame in progress complete when cfg_enable falls; no new frame SHALL start afterward.
REQ-029 SHALL give priority to the busy path when a tick and frame completion coincide; that tick SHALL count as missed.

Reset
REQ-030 SHALL, on reset=1 at a clk edge, set state=IDLE, all strobes=0, smp_valid=0, smp_sop=0, smp_eop=0, busy=0, missed_cnt=0, seq=0, period counter=0 and avm_address=0.
REQ-031 SHALL, on reset mid-frame, abandon the frame with no further strobes or stream words, leaving the partial frame to the consumer.

Verification
REQ-032 SHALL verify: NUM_SECTIONS=4, cfg_period=200, smp_ready=1 -> a 14-word frame every 200 cycles, sop on word 0, eop on word 13, seq 0,1,2.
REQ-033 SHALL verify: time_hi changes from 0 to 1 between RD_HI0 and RD_HI1 -> one restart, output hi=1 with the lo from the retry, tear=0.
REQ-034 SHALL verify: hi changing on 4 consecutive reads -> 3 restarts, then status word=0x80000000.
REQ-035 SHALL verify: smp_ready=0 for 500 cycles with cfg_period=100 -> data held stable and missed_cnt=4 or 5 at resume.
REQ-036 SHALL verify: cfg_clear=1 -> exactly one write at address 0 with data 0x1 and begintransfer after the final status word.
REQ-037 SHALL verify: reset asserted in RD_LO of section 2 -> next cycle all outputs at reset values and seq=0.

Source files
------------

// File: rtl/limbus_sys_perf_sampler.sv
// Purpose: periodic sampler that snapshots NUM_SECTIONS hi/lo/event counter sections over a
//          simple read master and streams each snapshot as a framed word sequence.
// Latency: frame starts the cycle after a period tick; each read takes RD_LATENCY+1 cycles.
// Backpressure: stream words stall in place while smp_ready=0; ticks arriving while busy are
//          counted in missed_cnt (saturating) instead of starting a frame.
// Ports:
//   clk, reset            single clock, synchronous active-high reset
//   cfg_enable/period     periodic tick generator control; period 0 disables ticks
//   cfg_clear             issue a global counter reset write after each frame's reads
//   avm_*                 counter register master (single-cycle read/write strobes)
//   smp_*                 sample stream: valid/ready with sop on header, eop on status
//   busy, missed_cnt      frame-in-progress flag and dropped-tick counter
module limbus_sys_perf_sampler #(
  parameter int NUM_SECTIONS = 4,
  parameter int RD_LATENCY   = 1
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_period,
  input  logic        cfg_clear,
  output logic [3:0]  avm_address,
  output logic        avm_read,
  output logic        avm_write,
  output logic        avm_begintransfer,
  output logic [31:0] avm_writedata,
  input  logic [31:0] avm_readdata,
  output logic [31:0] smp_data,
  output logic        smp_valid,
  input  logic        smp_ready,
  output logic        smp_sop,
  output logic        smp_eop,
  output logic        busy,
  output logic [15:0] missed_cnt
);

  typedef enum logic [3:0] {
    S_IDLE, S_HDR, S_RD_HI0, S_RD_LO, S_RD_HI1, S_RD_EV, S_EMIT, S_STAT, S_CLR
  } state_t;

  localparam logic [1:0] LAST_SEC  = 2'(NUM_SECTIONS - 1);
  localparam logic [2:0] LAT       = 3'(RD_LATENCY);
  localparam logic [1:0] MAX_RETRY = 2'd3;

  state_t      state, state_nxt;
  logic [1:0]  sec;
  logic [1:0]  retry;
  logic [1:0]  word_idx;
  logic        rd_pend;
  logic [2:0]  lat_cnt;
  logic [31:0] hi0_q, lo_q, hi1_q, ev_q;
  logic        tear_any;
  logic [31:0] hdr_word;
  logic [15:0] seq;

  logic [31:0] per_cnt;
  logic        prev_en;
  logic [31:0] prev_period;
  logic        run, reload, tick;

  logic        rd_state, rd_done, hi_mismatch;
  logic [7:0]  missed_sat8;

  // Period tick generator. Any enable rise or period change restarts the count so the
  // first tick after reconfiguration lands a full period later.
  assign run    = cfg_enable && (cfg_period != 32'd0);
  assign reload = (cfg_enable && !prev_en) || (cfg_period != prev_period);
  assign tick   = run && !reload && (per_cnt == cfg_period - 32'd1);

  always_ff @(posedge clk) begin
    if (reset) begin
      per_cnt     <= '0;
      prev_en     <= 1'b0;
      prev_period <= '0;
    end else begin
      prev_en     <= cfg_enable;
      prev_period <= cfg_period;
      if (!run || reload || tick) per_cnt <= '0;
      else                        per_cnt <= per_cnt + 32'd1;
    end
  end

  assign rd_state    = (state == S_RD_HI0) || (state == S_RD_LO) ||
                       (state == S_RD_HI1) || (state == S_RD_EV);
  // Read data is captured exactly RD_LATENCY cycles after the issue cycle.
  assign rd_done     = rd_pend && (lat_cnt == LAT);
  assign hi_mismatch = (avm_readdata != hi0_q);
  assign missed_sat8 = (missed_cnt > 16'd255) ? 8'hFF : missed_cnt[7:0];
  assign busy        = (state != S_IDLE);

  always_ff @(posedge clk) begin
    if (reset) state <= S_IDLE;
    else       state <= state_nxt;
  end

  always_comb begin
    state_nxt         = state;
    avm_address       = 4'd0;
    avm_read          = 1'b0;
    avm_write         = 1'b0;
    avm_begintransfer = 1'b0;
    avm_writedata     = 32'd0;
    smp_valid         = 1'b0;
    smp_data          = 32'd0;
    smp_sop           = 1'b0;
    smp_eop           = 1'b0;
    case (state)
      S_IDLE: if (tick) state_nxt = S_HDR;
      S_HDR: begin
        smp_valid = 1'b1;
        smp_sop   = 1'b1;
        smp_data  = hdr_word;
        if (smp_ready) state_nxt = S_RD_HI0;
      end
      S_RD_HI0: begin
        avm_address = {sec, 2'd1};
        avm_read    = !rd_pend;
        if (rd_done) state_nxt = S_RD_LO;
      end
      S_RD_LO: begin
        avm_address = {sec, 2'd0};
        avm_read    = !rd_pend;
        if (rd_done) state_nxt = S_RD_HI1;
      end
      S_RD_HI1: begin
        avm_address = {sec, 2'd1};
        avm_read    = !rd_pend;
        // A hi rollover between the two hi reads means lo may belong to either epoch.
        if (rd_done) state_nxt = (hi_mismatch && retry != MAX_RETRY) ? S_RD_HI0 : S_RD_EV;
      end
      S_RD_EV: begin
        avm_address = {sec, 2'd2};
        avm_read    = !rd_pend;
        if (rd_done) state_nxt = S_EMIT;
      end
      S_EMIT: begin
        smp_valid = 1'b1;
        case (word_idx)
          2'd0:    smp_data = lo_q;
          2'd1:    smp_data = hi1_q;
          default: smp_data = ev_q;
        endcase
        if (smp_ready && word_idx == 2'd2)
          state_nxt = (sec == LAST_SEC) ? S_STAT : S_RD_HI0;
      end
      S_STAT: begin
        smp_valid = 1'b1;
        smp_eop   = 1'b1;
        smp_data  = {tear_any, 31'd0};
        if (smp_ready) state_nxt = cfg_clear ? S_CLR : S_IDLE;
      end
      S_CLR: begin
        avm_write         = 1'b1;
        avm_begintransfer = 1'b1;
        avm_address       = 4'd0;
        avm_writedata     = 32'd1;
        state_nxt         = S_IDLE;
      end
      default: state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      sec        <= '0;
      retry      <= '0;
      word_idx   <= '0;
      rd_pend    <= 1'b0;
      lat_cnt    <= '0;
      hi0_q      <= '0;
      lo_q       <= '0;
      hi1_q      <= '0;
      ev_q       <= '0;
      tear_any   <= 1'b0;
      hdr_word   <= '0;
      seq        <= '0;
      missed_cnt <= '0;
    end else begin
      if (tick && state != S_IDLE && missed_cnt != 16'hFFFF)
        missed_cnt <= missed_cnt + 16'd1;

      // Header is frozen at frame start so it stays stable under backpressure; its tear
      // bit is always 0 because tearing is only known after the reads.
      if (state == S_IDLE && tick) begin
        hdr_word <= {1'b0, missed_sat8, 7'd0, seq};
        tear_any <= 1'b0;
        sec      <= '0;
        retry    <= '0;
        word_idx <= '0;
      end

      if (rd_state) begin
        if (!rd_pend) begin
          rd_pend <= 1'b1;
          lat_cnt <= 3'd1;
        end else if (rd_done) begin
          rd_pend <= 1'b0;
        end else begin
          lat_cnt <= lat_cnt + 3'd1;
        end
      end

      if (rd_done) begin
        case (state)
          S_RD_HI0: hi0_q <= avm_readdata;
          S_RD_LO:  lo_q  <= avm_readdata;
          S_RD_HI1: begin
            hi1_q <= avm_readdata;
            if (hi_mismatch) begin
              if (retry == MAX_RETRY) tear_any <= 1'b1;
              else                    retry    <= retry + 2'd1;
            end
          end
          S_RD_EV:  ev_q  <= avm_readdata;
          default:  ;
        endcase
      end

      if (state == S_EMIT && smp_ready) begin
        if (word_idx == 2'd2) begin
          word_idx <= '0;
          retry    <= '0;
          sec      <= sec + 2'd1;
        end else begin
          word_idx <= word_idx + 2'd1;
        end
      end

      if (state == S_STAT && smp_ready) seq <= seq + 16'd1;
    end
  end

endmodule

// File: tb/tb_limbus_sys_perf_sampler.sv
module tb_limbus_sys_perf_sampler;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_period = 32'd0;
  logic        cfg_clear = 1'b0;
  logic [3:0]  avm_address;
  logic        avm_read, avm_write, avm_begintransfer;
  logic [31:0] avm_writedata;
  logic [31:0] avm_readdata = 32'd0;
  logic [31:0] smp_data;
  logic        smp_valid, smp_sop, smp_eop;
  logic        smp_ready = 1'b1;
  logic        busy;
  logic [15:0] missed_cnt;

  always #5 clk = ~clk;

  limbus_sys_perf_sampler #(.NUM_SECTIONS(4), .RD_LATENCY(1)) dut (
    .clk(clk), .reset(reset), .cfg_enable(cfg_enable), .cfg_period(cfg_period),
    .cfg_clear(cfg_clear), .avm_address(avm_address), .avm_read(avm_read),
    .avm_write(avm_write), .avm_begintransfer(avm_begintransfer),
    .avm_writedata(avm_writedata), .avm_readdata(avm_readdata),
    .smp_data(smp_data), .smp_valid(smp_valid), .smp_ready(smp_ready),
    .smp_sop(smp_sop), .smp_eop(smp_eop), .busy(busy), .missed_cnt(missed_cnt)
  );

  int n_pass = 0;
  int n_total = 0;
  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  // Scoreboard entries are {sop, eop, data}.
  logic [33:0] exp_q[$];
  int          sop_t[$];
  int          eop_cyc = 0;
  int          wr_cyc = 0;
  int          n_writes = 0;
  int          hold_cycles = 0;
  int          hold_viol = 0;
  logic        prev_v = 1'b0, prev_r = 1'b0;
  logic [33:0] prev_word = '0;

  int lo_reads[16];
  int hi_reads1 = 0;
  int hi_mode = 0;

  task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h want %0h", nm, act, exp);
  endtask

  function automatic logic [31:0] lo_val(input int s, input int k);
    return 32'h1000_0000 | (32'(s * 4) << 8) | 32'(k);
  endfunction
  function automatic logic [31:0] hi_val(input int s);
    return 32'h2000_0000 | 32'(s * 4 + 1);
  endfunction
  function automatic logic [31:0] ev_val(input int s);
    return 32'hE000_0000 | 32'(s * 4 + 2);
  endfunction

  // Counter register model: lo words carry a per-address read count so a retried lo is
  // distinguishable; hi of section 0 can be made to roll over between reads.
  always @(negedge clk) begin
    if (avm_read === 1'b1) begin
      case (avm_address[1:0])
        2'd0: begin
          avm_readdata = lo_val(int'(avm_address[3:2]), lo_reads[avm_address]);
          lo_reads[avm_address]++;
        end
        2'd1: begin
          if (avm_address == 4'd1 && hi_mode != 0) begin
            if (hi_mode == 1) avm_readdata = (hi_reads1 == 0) ? 32'd0 : 32'd1;
            else              avm_readdata = 32'(hi_reads1);
            hi_reads1++;
          end else begin
            avm_readdata = hi_val(int'(avm_address[3:2]));
          end
        end
        2'd2:    avm_readdata = ev_val(int'(avm_address[3:2]));
        default: avm_readdata = 32'd0;
      endcase
    end
  end

  // Stream monitor: pops the scoreboard on every accepted word and tracks stalls.
  always @(negedge clk) begin
    logic [33:0] e;
    if (smp_valid === 1'b1 && smp_ready === 1'b1) begin
      if (exp_q.size() == 0) begin
        n_total++;
        $display("FAIL unexpected_word: got %h sop=%b eop=%b want no word", smp_data, smp_sop, smp_eop);
      end else begin
        e = exp_q.pop_front();
        chk("stream_word", 64'({smp_sop, smp_eop, smp_data}), 64'(e));
        if (smp_sop) sop_t.push_back(cyc);
        if (smp_eop) eop_cyc = cyc;
      end
    end
    if (prev_v && !prev_r) begin
      hold_cycles++;
      if (smp_valid !== 1'b1 || {smp_sop, smp_eop, smp_data} !== prev_word) hold_viol++;
    end
    prev_v    = smp_valid;
    prev_r    = smp_ready;
    prev_word = {smp_sop, smp_eop, smp_data};
  end

  always @(negedge clk) begin
    if (avm_write === 1'b1) begin
      n_writes++;
      wr_cyc = cyc;
      chk("clr_addr", 64'(avm_address), 64'd0);
      chk("clr_data", 64'(avm_writedata), 64'd1);
      chk("clr_begintransfer", 64'(avm_begintransfer), 64'd1);
    end
  end

  task automatic push_frame(input logic [15:0] seq, input int k, input logic [31:0] s0_lo,
                            input logic [31:0] s0_hi, input logic tear);
    exp_q.push_back({2'b10, 16'd0, seq});
    for (int s = 0; s < 4; s++) begin
      exp_q.push_back({2'b00, (s == 0) ? s0_lo : lo_val(s, k)});
      exp_q.push_back({2'b00, (s == 0) ? s0_hi : hi_val(s)});
      exp_q.push_back({2'b00, ev_val(s)});
    end
    exp_q.push_back({2'b01, tear, 31'd0});
  endtask

  task automatic init_model(input int mode);
    for (int i = 0; i < 16; i++) lo_reads[i] = 0;
    hi_reads1 = 0;
    hi_mode   = mode;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    cfg_enable = 1'b0;
    repeat (2) @(posedge clk);
    #1 reset = 1'b0;
  endtask

  task automatic wait_busy(input logic lvl, input int budget, input string nm);
    int n = 0;
    while (busy !== lvl && n < budget) begin
      @(negedge clk);
      n++;
    end
    chk(nm, 64'(busy), 64'(lvl));
  endtask

  task automatic run_one_frame(input logic [31:0] period, input string nm);
    cfg_period = period;
    cfg_enable = 1'b1;
    wait_busy(1'b1, 400, {nm, "_start"});
    cfg_enable = 1'b0;
    wait_busy(1'b0, 400, {nm, "_end"});
    chk({nm, "_all_words"}, 64'(exp_q.size()), 64'd0);
  endtask

  initial begin
    #500000;
    $display("FAIL watchdog: got timeout want completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int n;
    logic [3:0] rst_vec;

    // Reset state
    do_reset();
    @(negedge clk);
    chk("reset_busy", 64'(busy), 64'd0);
    chk("reset_missed", 64'(missed_cnt), 64'd0);
    chk("reset_stream", 64'({smp_valid, smp_sop, smp_eop}), 64'd0);

    // Three back-to-back periodic frames, seq 0..2, one every 200 cycles
    init_model(0);
    sop_t.delete();
    for (int f = 0; f < 3; f++) push_frame(16'(f), f, lo_val(0, f), hi_val(0), 1'b0);
    cfg_period = 32'd200;
    cfg_enable = 1'b1;
    n = 0;
    while (exp_q.size() != 0 && n < 1200) begin
      @(negedge clk);
      n++;
    end
    cfg_enable = 1'b0;
    chk("periodic_frames_done", 64'(exp_q.size()), 64'd0);
    chk("periodic_sop_count", 64'(sop_t.size()), 64'd3);
    chk("period_f0_f1", 64'((sop_t.size() >= 2) ? sop_t[1] - sop_t[0] : -1), 64'd200);
    chk("period_f1_f2", 64'((sop_t.size() >= 3) ? sop_t[2] - sop_t[1] : -1), 64'd200);
    wait_busy(1'b0, 200, "periodic_idle");

    // Single hi rollover: one restart, retried lo, no tear
    do_reset();
    init_model(1);
    push_frame(16'd0, 0, lo_val(0, 1), 32'd1, 1'b0);
    run_one_frame(32'd60, "one_restart");

    // Hi changes on every read: three restarts then accept with tear
    do_reset();
    init_model(2);
    push_frame(16'd0, 0, lo_val(0, 3), 32'd7, 1'b1);
    run_one_frame(32'd60, "tear");
    chk("no_write_without_clear", 64'(n_writes), 64'd0);

    // Stream stalled for 500 cycles while ticks keep arriving
    do_reset();
    init_model(0);
    hold_cycles = 0;
    hold_viol = 0;
    smp_ready = 1'b0;
    push_frame(16'd0, 0, lo_val(0, 0), hi_val(0), 1'b0);
    cfg_period = 32'd100;
    cfg_enable = 1'b1;
    wait_busy(1'b1, 300, "stall_start");
    repeat (500) @(posedge clk);
    #1;
    chk("missed_4_or_5", 64'(missed_cnt == 16'd4 || missed_cnt == 16'd5), 64'd1);
    cfg_enable = 1'b0;
    smp_ready = 1'b1;
    wait_busy(1'b0, 400, "stall_end");
    chk("stall_all_words", 64'(exp_q.size()), 64'd0);
    chk("stall_hold_viol", 64'(hold_viol), 64'd0);
    chk("stall_hold_seen", 64'(hold_cycles >= 400), 64'd1);

    // Clear write after the status word
    do_reset();
    init_model(0);
    n_writes = 0;
    cfg_clear = 1'b1;
    push_frame(16'd0, 0, lo_val(0, 0), hi_val(0), 1'b0);
    run_one_frame(32'd60, "clear");
    cfg_clear = 1'b0;
    chk("clear_write_count", 64'(n_writes), 64'd1);
    chk("clear_after_eop", 64'(wr_cyc > eop_cyc), 64'd1);

    // Reset during RD_LO of section 2 of the second frame
    do_reset();
    init_model(0);
    push_frame(16'd0, 0, lo_val(0, 0), hi_val(0), 1'b0);
    push_frame(16'd1, 1, lo_val(0, 1), hi_val(0), 1'b0);
    cfg_period = 32'd100;
    cfg_enable = 1'b1;
    n = 0;
    while (exp_q.size() > 14 && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("abort_first_frame", 64'(exp_q.size()), 64'd14);
    n = 0;
    while (!(avm_read === 1'b1 && avm_address === 4'd8) && n < 600) begin
      @(negedge clk);
      n++;
    end
    chk("abort_reached_rd_lo_s2", 64'(avm_address), 64'd8);
    reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    rst_vec = {avm_read, avm_write, avm_begintransfer, busy};
    chk("abort_strobes_busy", 64'(rst_vec), 64'd0);
    chk("abort_addr", 64'(avm_address), 64'd0);
    chk("abort_stream", 64'({smp_valid, smp_sop, smp_eop}), 64'd0);
    chk("abort_missed", 64'(missed_cnt), 64'd0);
    exp_q.delete();
    init_model(0);
    push_frame(16'd0, 0, lo_val(0, 0), hi_val(0), 1'b0);
    @(posedge clk);
    #1 reset = 1'b0;
    wait_busy(1'b1, 400, "after_abort_start");
    cfg_enable = 1'b0;
    wait_busy(1'b0, 400, "after_abort_end");
    chk("after_abort_seq0_frame", 64'(exp_q.size()), 64'd0);

    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule
